// File: rtl/clk_gate_ctrl_pkg.sv
// rtl/clk_gate_ctrl_pkg.sv - shared state encoding and decode helpers for the clock-gating controller
package clk_gate_ctrl_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_WAKE  = 3'd1,
        ST_ON    = 3'd2,
        ST_IDLE  = 3'd3,
        ST_GATED = 3'd4
    } ch_state_t;

    function automatic logic st_enable(input ch_state_t s);
        case (s)
            ST_WAKE, ST_ON, ST_IDLE: st_enable = 1'b1;
            default:                 st_enable = 1'b0;
        endcase
    endfunction

    function automatic logic st_ack(input ch_state_t s);
        case (s)
            ST_ON, ST_IDLE: st_ack = 1'b1;
            default:        st_ack = 1'b0;
        endcase
    endfunction

    // Anything not driving a clock (including encodings outside the enum) reports as gated.
    function automatic logic st_gated(input ch_state_t s);
        case (s)
            ST_WAKE, ST_ON, ST_IDLE: st_gated = 1'b0;
            default:                 st_gated = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/clk_gate_cell.sv
// rtl/clk_gate_cell.sv - latch-plus-AND integrated clock gate, transparent while CLK is low
module clk_gate_cell (
    input  logic CLK,
    input  logic CLK_EN,
    input  logic test_en,
    output logic GATED_CLK
);

    logic en_latch;

    // Behavioural model of the library ICG; enable is only sampled in the low
    // phase so a change while CLK is high can never shorten a high pulse.
    always_latch begin
        if (!CLK) begin
            en_latch <= CLK_EN | test_en;
        end
    end

    assign GATED_CLK = CLK & en_latch;

endmodule

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - multi-channel clock-gating controller with idle timeout and wake handshake
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              test_en,
    input  logic [NUM_CH-1:0] sw_en,
    input  logic [NUM_CH-1:0] busy,
    input  logic [NUM_CH-1:0] wake_req,
    input  logic [CNT_W-1:0]  idle_thr,
    output logic [NUM_CH-1:0] GATED_CLK,
    output logic [NUM_CH-1:0] clk_ack,
    output logic [NUM_CH-1:0] gated_sts
);

    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [CNT_W-1:0]  idle_last;
    logic              thr_zero;
    logic [NUM_CH-1:0] gate_en;

    assign idle_last = idle_thr - CNT_W'(1);
    assign thr_zero  = (idle_thr == '0);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        ch_state_t        state_q;
        logic [CNT_W-1:0] idle_cnt_q;
        logic [CNT_W-1:0] wake_cnt_q;
        logic             activity;

        assign activity = busy[ch] | wake_req[ch];

        always_ff @(posedge CLK or negedge RST) begin
            if (!RST) begin
                state_q    <= ST_OFF;
                idle_cnt_q <= '0;
                wake_cnt_q <= '0;
            end else if (!sw_en[ch]) begin
                state_q    <= ST_OFF;
                idle_cnt_q <= '0;
                wake_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_OFF: begin
                        state_q    <= ST_WAKE;
                        wake_cnt_q <= '0;
                    end
                    ST_WAKE: begin
                        if (wake_cnt_q == WAKE_LAST) begin
                            state_q    <= ST_ON;
                            wake_cnt_q <= '0;
                        end else begin
                            wake_cnt_q <= wake_cnt_q + CNT_W'(1);
                        end
                    end
                    ST_ON: begin
                        if (!activity && !thr_zero) begin
                            state_q    <= ST_IDLE;
                            idle_cnt_q <= '0;
                        end
                    end
                    ST_IDLE: begin
                        // A threshold lowered below the running count gates on the next edge.
                        if (activity || thr_zero) begin
                            state_q    <= ST_ON;
                            idle_cnt_q <= '0;
                        end else if (idle_cnt_q >= idle_last) begin
                            state_q    <= ST_GATED;
                            idle_cnt_q <= '0;
                        end else if (idle_cnt_q != CNT_MAX) begin
                            idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                        end
                    end
                    ST_GATED: begin
                        if (activity) begin
                            state_q    <= ST_WAKE;
                            wake_cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q    <= ST_OFF;
                        idle_cnt_q <= '0;
                        wake_cnt_q <= '0;
                    end
                endcase
            end
        end

        assign gate_en[ch]   = st_enable(state_q);
        assign clk_ack[ch]   = st_ack(state_q);
        assign gated_sts[ch] = st_gated(state_q);

        clk_gate_cell u_cell (
            .CLK       (CLK),
            .CLK_EN    (gate_en[ch]),
            .test_en   (test_en),
            .GATED_CLK (GATED_CLK[ch])
        );
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - directed self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

    localparam int NUM_CH   = 2;
    localparam int CNT_W    = 8;
    localparam int WAKE_CYC = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              test_en;
    logic [NUM_CH-1:0] sw_en;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] wake_req;
    logic [CNT_W-1:0]  idle_thr;
    logic [NUM_CH-1:0] GATED_CLK;
    logic [NUM_CH-1:0] clk_ack;
    logic [NUM_CH-1:0] gated_sts;

    int n_cmp = 0;
    int n_err = 0;

    clk_gate_ctrl #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .WAKE_CYC (WAKE_CYC)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .test_en   (test_en),
        .sw_en     (sw_en),
        .busy      (busy),
        .wake_req  (wake_req),
        .idle_thr  (idle_thr),
        .GATED_CLK (GATED_CLK),
        .clk_ack   (clk_ack),
        .gated_sts (gated_sts)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Samples and drives 2 time units into the CLK high phase.
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b0;
        test_en  = 1'b0;
        sw_en    = '0;
        busy     = '0;
        wake_req = '0;
        idle_thr = '0;

        // Reset values
        repeat (3) tick();
        check("rst_ack", clk_ack, 2'b00);
        check("rst_sts", gated_sts, 2'b11);
        check("rst_gclk", GATED_CLK, 2'b00);
        RST = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            check("off_ack", clk_ack, 2'b00);
            check("off_sts", gated_sts, 2'b11);
            check("off_gclk", GATED_CLK, 2'b00);
        end

        // Enable channel 0: WAKE then ON with WAKE_CYC=2
        sw_en = 2'b01;
        tick();
        check("wake1_ack", clk_ack, 2'b00);
        check("wake1_sts", gated_sts, 2'b10);
        check("wake1_gclk", GATED_CLK, 2'b00);
        tick();
        check("wake2_ack", clk_ack, 2'b00);
        check("wake2_gclk", GATED_CLK, 2'b01);
        tick();
        check("on_ack", clk_ack, 2'b01);
        check("on_sts", gated_sts, 2'b10);
        check("on_gclk", GATED_CLK, 2'b01);

        // Idle timeout of 4 with a busy pulse restarting the count
        idle_thr = 8'd4;
        busy     = 2'b01;
        tick();
        busy = 2'b00;
        tick();
        tick();
        busy = 2'b01;
        tick();
        busy = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle_ack", clk_ack, 2'b01);
        end
        tick();
        check("gate_ack", clk_ack, 2'b00);
        check("gate_sts", gated_sts, 2'b11);
        check("gate_gclk_last", GATED_CLK, 2'b01);
        tick();
        check("gate_gclk_stop", GATED_CLK, 2'b00);

        // wake_req pulse from GATED, then idle_thr=0 holds ON
        idle_thr = 8'd0;
        wake_req = 2'b01;
        tick();
        wake_req = 2'b00;
        check("rewake1_ack", clk_ack, 2'b00);
        check("rewake1_sts", gated_sts, 2'b10);
        tick();
        check("rewake2_ack", clk_ack, 2'b00);
        tick();
        check("rewake3_ack", clk_ack, 2'b01);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_ack", clk_ack, 2'b01);
            check("hold_gclk", GATED_CLK, 2'b01);
        end

        // Threshold lowered below a running count gates on the next edge
        idle_thr = 8'd10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("thr_cnt_ack", clk_ack, 2'b01);
        end
        idle_thr = 8'd3;
        tick();
        check("thr_drop_ack", clk_ack, 2'b00);
        check("thr_drop_sts", gated_sts, 2'b11);

        // DFT override with both channels OFF
        sw_en = 2'b00;
        tick();
        check("dft_off_ack", clk_ack, 2'b00);
        test_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("dft_gclk_hi", GATED_CLK, 2'b11);
            check("dft_sts", gated_sts, 2'b11);
            check("dft_ack", clk_ack, 2'b00);
            @(negedge CLK);
            #2;
            check("dft_gclk_lo", GATED_CLK, 2'b00);
        end
        tick();
        test_en = 1'b0;
        #1;
        check("dft_release_hold", GATED_CLK, 2'b11);
        tick();
        check("dft_release_stop", GATED_CLK, 2'b00);

        // Reset with channel 0 in IDLE and channel 1 in WAKE
        idle_thr = 8'd8;
        sw_en    = 2'b01;
        repeat (4) tick();
        check("pre_rst_ack0", clk_ack, 2'b01);
        sw_en = 2'b11;
        tick();
        check("pre_rst_ack", clk_ack, 2'b01);
        check("pre_rst_sts", gated_sts, 2'b00);
        check("pre_rst_gclk", GATED_CLK, 2'b01);
        RST = 1'b0;
        #1;
        check("async_rst_ack", clk_ack, 2'b00);
        check("async_rst_sts", gated_sts, 2'b11);
        check("async_rst_no_trunc", GATED_CLK, 2'b01);
        @(negedge CLK);
        #1;
        check("async_rst_gclk_lo", GATED_CLK, 2'b00);
        tick();
        check("async_rst_gclk_hi", GATED_CLK, 2'b00);
        check("async_rst_ack2", clk_ack, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
